// File: rtl/mdio_phy_init_pkg.sv
// MDIO PHY init sequencer: shared types, opcodes and the init table.
// Read-back verification is enabled by defining MDIO_VERIFY_EN.
package mdio_phy_init_pkg;

  typedef enum logic [2:0] {
    RST_ASSERT,
    RST_WAIT,
    LOAD,
    SHIFT,
    GAP,
    NEXT,
    DONE
  } state_t;

  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] TA_WR = 2'b10;

  localparam int INIT_LEN = 4;

  typedef logic [20:0] init_entry_t;

  localparam init_entry_t INIT_TABLE [INIT_LEN] = '{
    {5'h00, 16'h1140},
    {5'h10, 16'h5848},
    {5'h14, 16'h29C7},
    {5'h00, 16'h1340}
  };

  // Bits 15 and 9 self-clear in the PHY and never read back as written.
  localparam logic [15:0] RD_CMP_MASK = 16'h7DFF;

  localparam logic [63:0] RD_TMASK = 64'h0000_0000_0003_FFFF;

  function automatic logic [63:0] build_frame(
    input logic [4:0]  phyad,
    input init_entry_t e,
    input logic        rd
  );
    logic [1:0]  op;
    logic [1:0]  ta;
    logic [15:0] d;
    op = rd ? OP_RD : OP_WR;
    ta = rd ? 2'b11 : TA_WR;
    d  = rd ? 16'hFFFF : e[15:0];
    return {32'hFFFF_FFFF, 2'b01, op, phyad, e[20:16], ta, d};
  endfunction

endpackage

// File: rtl/mdio_frame_shifter.sv
// MDC divider plus 64-bit MDIO shift/sample engine, followed by one
// idle gap bit; start loads a frame, done marks the end of the gap.
module mdio_frame_shifter #(
  parameter int MDC_DIV = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] frame,
  input  logic [63:0] rd_mask,
  input  logic        mdio_i,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_t,
  output logic        gap,
  output logic        done,
  output logic [15:0] rdata
);

  localparam int CW = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MDC_DIV - 1);

  logic          run;
  logic [CW-1:0] cnt;
  logic [6:0]    bitn;
  logic [63:0]   sreg;
  logic [63:0]   tmask;
  logic          wrap;
  logic          last;

  assign wrap = run && (cnt == CNT_MAX);
  assign last = (bitn == 7'd64);

  always_ff @(posedge clk) begin
    if (reset) begin
      run   <= 1'b0;
      cnt   <= '0;
      mdc   <= 1'b0;
      bitn  <= '0;
      sreg  <= '1;
      tmask <= '1;
      rdata <= '0;
    end else if (start) begin
      run   <= 1'b1;
      cnt   <= '0;
      mdc   <= 1'b0;
      bitn  <= '0;
      sreg  <= frame;
      tmask <= rd_mask;
    end else if (wrap) begin
      cnt <= '0;
      mdc <= ~mdc;
      if (mdc) begin
        if (last) begin
          run <= 1'b0;
        end else begin
          bitn  <= bitn + 7'd1;
          sreg  <= {sreg[62:0], 1'b1};
          tmask <= {tmask[62:0], 1'b1};
        end
      end else if (!last) begin
        rdata <= {rdata[14:0], mdio_i};
      end
    end else if (run) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign mdio_o = (run && !last) ? sreg[63]  : 1'b1;
  assign mdio_t = (run && !last) ? tmask[63] : 1'b1;
  assign gap    = run && last;
  assign done   = wrap && mdc && last;

endmodule

// File: rtl/mdio_phy_init_sequencer.sv
// PHY reset + Clause-22 init writes, then MDIO pass-through to the CPU.
// Define MDIO_VERIFY_EN to read back and check every written register.
module mdio_phy_init_sequencer
  import mdio_phy_init_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR          = 5'd3,
  parameter int         MDC_DIV           = 50,
  parameter int         RESET_CYCLES      = 2500,
  parameter int         POST_RESET_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic init_start,
  input  logic cpu_mdc,
  input  logic cpu_mdio_o,
  input  logic cpu_mdio_t,
  output logic cpu_mdio_i,
  output logic mdio_mdc_mdc,
  output logic mdio_mdc_mdio_o,
  output logic mdio_mdc_mdio_t,
  input  logic mdio_mdc_mdio_i,
  output logic phy_reset_out,
  output logic init_busy,
  output logic init_done,
  output logic init_error
);

  localparam int WMAX = (RESET_CYCLES > POST_RESET_CYCLES) ?
                        RESET_CYCLES : POST_RESET_CYCLES;
  localparam int WCW  = $clog2(WMAX + 1);
  localparam int IW   = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;

  localparam logic [WCW-1:0] RST_LAST  = WCW'(RESET_CYCLES - 1);
  localparam logic [WCW-1:0] POST_LAST = WCW'(POST_RESET_CYCLES - 1);
  localparam logic [IW-1:0]  IDX_LAST  = IW'(INIT_LEN - 1);

  state_t         state, state_n;
  logic [WCW-1:0] wcnt, wcnt_n;
  logic [IW-1:0]  idx, idx_n;
  logic           rd_ph, rd_ph_n;
  logic           err, err_n;
  logic           phy_rst;

  init_entry_t    entry;
  logic [63:0]    sh_frame;
  logic [63:0]    sh_tmask;
  logic           sh_start;
  logic           sh_mdc;
  logic           sh_o;
  logic           sh_t;
  logic           sh_gap;
  logic           sh_done;
  logic [15:0]    sh_rdata;
  logic           advance;

  assign entry    = INIT_TABLE[idx];
  assign sh_frame = build_frame(PHY_ADDR, entry, rd_ph);
  assign sh_tmask = rd_ph ? RD_TMASK : '0;

  mdio_frame_shifter #(
    .MDC_DIV (MDC_DIV)
  ) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .start   (sh_start),
    .frame   (sh_frame),
    .rd_mask (sh_tmask),
    .mdio_i  (mdio_mdc_mdio_i),
    .mdc     (sh_mdc),
    .mdio_o  (sh_o),
    .mdio_t  (sh_t),
    .gap     (sh_gap),
    .done    (sh_done),
    .rdata   (sh_rdata)
  );

  always_comb begin
    state_n  = state;
    wcnt_n   = wcnt;
    idx_n    = idx;
    rd_ph_n  = rd_ph;
    err_n    = err;
    sh_start = 1'b0;
    advance  = 1'b0;
    unique case (state)
      RST_ASSERT: begin
        if (wcnt == RST_LAST) begin
          state_n = RST_WAIT;
          wcnt_n  = '0;
        end else begin
          wcnt_n = wcnt + WCW'(1);
        end
      end
      RST_WAIT: begin
        if (wcnt == POST_LAST) begin
          state_n = LOAD;
          wcnt_n  = '0;
        end else begin
          wcnt_n = wcnt + WCW'(1);
        end
      end
      LOAD: begin
        sh_start = 1'b1;
        state_n  = SHIFT;
      end
      SHIFT: begin
        if (sh_gap) state_n = GAP;
      end
      GAP: begin
        if (sh_done) state_n = NEXT;
      end
      NEXT: begin
`ifdef MDIO_VERIFY_EN
        if (!rd_ph) begin
          rd_ph_n = 1'b1;
          state_n = LOAD;
        end else begin
          rd_ph_n = 1'b0;
          if (((sh_rdata ^ entry[15:0]) & RD_CMP_MASK) != '0)
            err_n = 1'b1;
          advance = 1'b1;
        end
`else
        advance = 1'b1;
`endif
        if (advance) begin
          if (idx == IDX_LAST) begin
            state_n = DONE;
          end else begin
            idx_n   = idx + IW'(1);
            state_n = LOAD;
          end
        end
      end
      DONE: begin
        if (init_start) begin
          state_n = RST_ASSERT;
          wcnt_n  = '0;
          idx_n   = '0;
          rd_ph_n = 1'b0;
          err_n   = 1'b0;
        end
      end
      default: state_n = RST_ASSERT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RST_ASSERT;
      wcnt    <= '0;
      idx     <= '0;
      rd_ph   <= 1'b0;
      err     <= 1'b0;
      phy_rst <= 1'b0;
    end else begin
      state   <= state_n;
      wcnt    <= wcnt_n;
      idx     <= idx_n;
      rd_ph   <= rd_ph_n;
      err     <= err_n;
      phy_rst <= (state_n != RST_ASSERT);
    end
  end

  assign phy_reset_out = phy_rst;
  assign init_busy     = (state != DONE);
  assign init_done     = (state == DONE);

  assign mdio_mdc_mdc    = init_done ? cpu_mdc    : sh_mdc;
  assign mdio_mdc_mdio_o = init_done ? cpu_mdio_o : sh_o;
  assign mdio_mdc_mdio_t = init_done ? cpu_mdio_t : sh_t;
  assign cpu_mdio_i      = init_done ? mdio_mdc_mdio_i : 1'b1;

`ifdef MDIO_VERIFY_EN
  assign init_error = err;
`else
  logic unused_rd;
  assign unused_rd  = ^{sh_rdata, err};
  assign init_error = 1'b0;
`endif

endmodule
